// File: rtl/b1_fifo_rd_packer_if.sv
`default_nettype none
// ============================================================================
// b1_fifo_rd_packer_if : FIFO-read and packed-beat stream bundle | Rev 1.0
// ============================================================================
interface b1_fifo_rd_packer_if #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
);
  logic                      fifo_empty_i;
  logic [DWIDTH-1:0]         fifo_q_i;
  logic                      fifo_rdreq_o;
  logic                      flush_i;
  logic [RATIO*DWIDTH-1:0]   data_o;
  logic [RATIO-1:0]          keep_o;
  logic                      valid_o;
  logic                      ready_i;

  // master is the packer; slave is the FIFO/downstream environment
  modport master (
    input  fifo_empty_i, fifo_q_i, flush_i, ready_i,
    output fifo_rdreq_o, data_o, keep_o, valid_o
  );

  modport slave (
    output fifo_empty_i, fifo_q_i, flush_i, ready_i,
    input  fifo_rdreq_o, data_o, keep_o, valid_o
  );
endinterface
`default_nettype wire

// File: rtl/b1_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// b1_fifo_rd_packer : packs RATIO non-showahead FIFO words per beat | Rev 1.0
// ============================================================================
module b1_fifo_rd_packer #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  wire logic              clk_i,
  input  wire logic              rst_n_i,
  b1_fifo_rd_packer_if.master    bus
);

  localparam int              c_CW   = $clog2(RATIO + 1);
  localparam int              c_BW   = RATIO * DWIDTH;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(RATIO);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic             flush_pend_q, flush_pend_d;
  logic [c_BW-1:0]  asm_q, asm_d;
  logic [c_BW-1:0]  data_q, data_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             valid_q, valid_d;

  logic [c_CW-1:0]  w_cnt_cap;
  logic [c_BW-1:0]  w_asm_cap;
  logic [RATIO-1:0] w_keep_new;
  logic             w_complete;
  logic             w_out_free;
  logic             w_load;
  logic             w_rdreq;

  // Assembly as it will look once the in-flight word (if any) lands this edge
  always_comb begin
    w_asm_cap = asm_q;
    w_cnt_cap = cnt_q;
    if (inflight_q) begin
      for (int k = 0; k < RATIO; k++) begin
        if (k == int'(cnt_q)) begin
          w_asm_cap[k*DWIDTH +: DWIDTH] = bus.fifo_q_i;
        end
      end
      w_cnt_cap = cnt_q + c_ONE;
    end
    for (int k = 0; k < RATIO; k++) begin
      w_keep_new[k] = (k < int'(w_cnt_cap));
    end
  end

  // Reads are blocked during flush, so a pending flush with words means no word is in flight
  assign w_complete = (w_cnt_cap == c_FULL) || (flush_pend_q && (w_cnt_cap != '0));
  assign w_out_free = !valid_q || bus.ready_i;
  assign w_load     = w_complete && w_out_free;

  // A full beat draining this edge frees slot 0 for the next word, keeping back-to-back reads
  assign w_rdreq = rst_n_i && !bus.fifo_empty_i && !flush_pend_q &&
                   (w_load || (w_cnt_cap != c_FULL));

  always_comb begin
    cnt_d        = w_cnt_cap;
    asm_d        = w_asm_cap;
    inflight_d   = w_rdreq;
    data_d       = data_q;
    keep_d       = keep_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    if (w_load) begin
      data_d       = w_asm_cap;
      keep_d       = w_keep_new;
      valid_d      = 1'b1;
      cnt_d        = '0;
      asm_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (valid_q && bus.ready_i) begin
        valid_d = 1'b0;
      end
      if (flush_pend_q && (w_cnt_cap == '0) && !inflight_q) begin
        flush_pend_d = 1'b0;
      end else if (bus.flush_i) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      asm_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      asm_q        <= asm_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.fifo_rdreq_o = w_rdreq;
  assign bus.data_o       = data_q;
  assign bus.keep_o       = keep_q;
  assign bus.valid_o      = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_b1_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// tb_b1_fifo_rd_packer : directed vector bench for b1_fifo_rd_packer | Rev 1.0
// ============================================================================
module tb_b1_fifo_rd_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  b1_fifo_rd_packer_if #(.DWIDTH(8), .RATIO(4)) bus ();

  b1_fifo_rd_packer #(.DWIDTH(8), .RATIO(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Non-showahead FIFO model: q updates one edge after an accepted rdreq
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;
  assign bus.fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rdreq_o && (wr_ptr != rd_ptr)) begin
      bus.fifo_q_i <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
      pops         <= pops + 1;
    end
  end

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    int          c;
  } beat_t;

  beat_t       bq[$];
  int          cyc = 0;
  int          vcyc = 0;
  int          rdcnt = 0;
  int          bad_rd = 0;
  int          stab = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = '0;
  logic [3:0]  pk = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_o && bus.ready_i) bq.push_back('{bus.data_o, bus.keep_o, cyc});
    if (bus.valid_o) vcyc++;
    if (bus.fifo_rdreq_o) rdcnt++;
    if (bus.fifo_rdreq_o && bus.fifo_empty_i) bad_rd++;
    if (pv && !pr && (!bus.valid_o || bus.data_o !== pd || bus.keep_o !== pk)) stab++;
    pv = bus.valid_o; pr = bus.ready_i; pd = bus.data_o; pk = bus.keep_o;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    bus.flush_i = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] beat_d(input int idx);
    return (bq.size() > idx) ? bq[idx].d : 32'hxxxxxxxx;
  endfunction

  function automatic logic [3:0] beat_k(input int idx);
    return (bq.size() > idx) ? bq[idx].k : 4'hx;
  endfunction

  typedef struct {
    int          n;
    logic [31:0] words;
    logic        flush;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int b0, v0, r0, base, guard;

    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
    vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'h3};
    vecs[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1};
    vecs[3] = '{3, 32'h00C3B2A1, 1'b1, 32'h00C3B2A1, 4'h7};
    vecs[4] = '{4, 32'hD4C3B2A1, 1'b1, 32'hD4C3B2A1, 4'hF};

    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;

    // Reset state, with data waiting in the FIFO
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(); tick();
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_data",  bus.data_o, 32'd0);
    check("rst_keep",  {28'd0, bus.keep_o}, 32'd0);
    check("rst_rdreq", {31'd0, bus.fifo_rdreq_o}, 32'd0);
    b0 = bq.size(); v0 = vcyc; r0 = rdcnt;
    rst_n = 1'b1;
    repeat (12) tick();
    check("basic_rdreq_cycles", rdcnt - r0, 4);
    check("basic_beats", bq.size() - b0, 1);
    check("basic_data", beat_d(b0), 32'h44332211);
    check("basic_keep", {28'd0, beat_k(b0)}, 32'hF);
    check("basic_valid_cycles", vcyc - v0, 1);

    // Table: single beats, full and flushed partial, flush landing with last word
    for (int i = 0; i < 5; i++) begin
      do_reset();
      b0 = bq.size(); v0 = vcyc; base = pops;
      bus.ready_i = 1'b1;
      for (int j = 0; j < vecs[i].n; j++) push(vecs[i].words[8*j +: 8]);
      if (vecs[i].flush) begin
        guard = 0;
        while ((pops - base) != vecs[i].n && guard < 50) begin
          tick();
          guard++;
        end
        check($sformatf("vec%0d_pop_wait", i), pops - base, vecs[i].n);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
      end
      repeat (12) tick();
      check($sformatf("vec%0d_beats", i), bq.size() - b0, 1);
      check($sformatf("vec%0d_data", i), beat_d(b0), vecs[i].exp_d);
      check($sformatf("vec%0d_keep", i), {28'd0, beat_k(b0)}, {28'd0, vecs[i].exp_k});
      check($sformatf("vec%0d_valid_cycles", i), vcyc - v0, 1);
    end

    // Backpressure: one held beat plus one assembly, then ordered drain
    do_reset();
    bus.ready_i = 1'b0;
    b0 = bq.size(); base = pops;
    for (int j = 1; j <= 12; j++) push(8'(j));
    repeat (20) tick();
    check("bp_popped", pops - base, 8);
    check("bp_valid", {31'd0, bus.valid_o}, 32'd1);
    check("bp_hold_data", bus.data_o, 32'h04030201);
    check("bp_stability", stab, 0);
    bus.ready_i = 1'b1;
    repeat (20) tick();
    check("bp_beats", bq.size() - b0, 3);
    check("bp_beat0", beat_d(b0), 32'h04030201);
    check("bp_beat1", beat_d(b0 + 1), 32'h08070605);
    check("bp_beat2", beat_d(b0 + 2), 32'h0C0B0A09);

    // Empty FIFO and flush with nothing assembled
    do_reset();
    b0 = bq.size(); r0 = rdcnt;
    repeat (5) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    repeat (5) tick();
    check("empty_no_rdreq", rdcnt - r0, 0);
    check("empty_flush_no_beat", bq.size() - b0, 0);
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    repeat (12) tick();
    check("after_empty_flush_beats", bq.size() - b0, 1);
    check("after_empty_flush_data", beat_d(b0), 32'h94939291);

    // Asynchronous reset mid-operation: held beat and partial assembly discarded
    do_reset();
    bus.ready_i = 1'b0;
    for (int j = 1; j <= 7; j++) push(8'h60 + 8'(j));
    repeat (14) tick();
    check("ar_pre_valid", {31'd0, bus.valid_o}, 32'd1);
    check("ar_pre_data", bus.data_o, 32'h64636261);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, bus.valid_o}, 32'd0);
    check("ar_data", bus.data_o, 32'd0);
    check("ar_keep", {28'd0, bus.keep_o}, 32'd0);
    check("ar_rdreq", {31'd0, bus.fifo_rdreq_o}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    b0 = bq.size();
    push(8'h81); push(8'h82); push(8'h83); push(8'h84);
    bus.ready_i = 1'b1;
    repeat (12) tick();
    check("ar_after_beats", bq.size() - b0, 1);
    check("ar_after_data", beat_d(b0), 32'h84838281);
    check("ar_after_keep", {28'd0, beat_k(b0)}, 32'hF);

    // Back-to-back: 16 words give 4 beats spaced exactly 4 cycles
    do_reset();
    bus.ready_i = 1'b1;
    b0 = bq.size();
    for (int j = 0; j < 16; j++) push(8'h10 + 8'(j));
    repeat (30) tick();
    check("b2b_beats", bq.size() - b0, 4);
    check("b2b_beat0", beat_d(b0),     32'h13121110);
    check("b2b_beat1", beat_d(b0 + 1), 32'h17161514);
    check("b2b_beat2", beat_d(b0 + 2), 32'h1B1A1918);
    check("b2b_beat3", beat_d(b0 + 3), 32'h1F1E1D1C);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("b2b_gap%0d", i),
            (bq.size() > b0 + i) ? (bq[b0 + i].c - bq[b0 + i - 1].c) : -1, 4);
    end

    check("rdreq_while_empty", bad_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
